// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential divider.
// Holds FSM state encodings, default width and counter sizing.
package divider_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ITER    = 2'd1,
    CORRECT = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Iteration counter width; never narrower than one bit.
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W_DEF = cnt_w(WIDTH_DEF);

endpackage

// File: rtl/adder_rca.sv
// W-bit ripple-carry adder: sum = a + b + cin.
// Ports: a, b (W), cin (1) in; sum (W), cout (1) out.
module adder_rca #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) |
                      (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[W];

endmodule

// File: rtl/divider_seq.sv
// Sequential unsigned non-restoring divider, one step per cycle.
// Ports: clk, rst_b, start, dividend, divisor in;
//        ready, done, quotient, remainder, div_by_zero out.
module divider_seq
  import divider_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH:0]   a;
  logic [WIDTH:0]   m;
  logic [WIDTH-1:0] q;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   x;
  logic [WIDTH:0]   y;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   corr;
  logic             cin;
  logic             add_cout_unused;

  // Single shared adder: ITER adds/subtracts M to shifted A,
  // CORRECT adds M back to A.
  always_comb begin
    shifted = {a[WIDTH-1:0], q[WIDTH-1]};
    x       = a;
    cin     = 1'b0;
    if (state == ITER) begin
      x   = shifted;
      cin = ~a[WIDTH];
    end
    y = cin ? ~m : m;
  end

  adder_rca #(
    .W (WIDTH + 1)
  ) u_add (
    .a    (x),
    .b    (y),
    .cin  (cin),
    .sum  (sum),
    .cout (add_cout_unused)
  );

  // Negative partial remainder gets M added back once.
  assign corr = a[WIDTH] ? sum : a;

  assign ready = (state == IDLE);
  assign done  = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state       <= IDLE;
      count       <= '0;
      a           <= '0;
      q           <= '0;
      m           <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              state       <= DONE;
            end else begin
              a           <= '0;
              q           <= dividend;
              m           <= {1'b0, divisor};
              count       <= '0;
              div_by_zero <= 1'b0;
              state       <= ITER;
            end
          end
        end
        ITER: begin
          a     <= sum;
          q     <= {q[WIDTH-2:0], ~sum[WIDTH]};
          count <= count + 1'b1;
          if (count == LAST) state <= CORRECT;
        end
        CORRECT: begin
          a         <= corr;
          quotient  <= q;
          remainder <= corr[WIDTH-1:0];
          state     <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_seq.sv
// Directed + random bench for divider_seq.
// Scoreboard queue of expected results, checked on done.
module tb_divider_seq;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic       ready;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] dd;
    logic [7:0] dv;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
  } exp_t;

  exp_t sbq[$];

  divider_seq #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [7:0] a,
                          input logic [7:0] b);
    exp_t e;
    @(negedge clk);
    e.dd = a;
    e.dv = b;
    if (b == 0) begin
      e.q = 8'hff;
      e.r = a;
      e.z = 1'b1;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.z = 1'b0;
    end
    sbq.push_back(e);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
  endtask

  // Counts edges from the accepting edge until done.
  // inj_at: pulse a competing start after that many edges.
  // inj_done: raise start in the DONE cycle.
  task automatic wait_done(input int exp_lat,
                           input string tag,
                           input int inj_at,
                           input bit inj_done,
                           input bit inv);
    int   lat;
    bit   seen;
    bit   busy_rdy;
    exp_t e;
    logic [7:0] q_hold;
    lat      = 0;
    seen     = 1'b0;
    busy_rdy = 1'b0;
    while (lat < 40 && !seen) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      start = 1'b0;
      if (done) seen = 1'b1;
      else if (ready) busy_rdy = 1'b1;
      if (!seen && lat == inj_at) begin
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd5;
      end
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_busy_ready"}, busy_rdy, 1'b0);
    if (sbq.size() == 0) begin
      chk({tag, "_sb_empty"}, 1'b1, 1'b0);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_q"}, quotient, e.q);
      chk({tag, "_r"}, remainder, e.r);
      chk({tag, "_dbz"}, div_by_zero, e.z);
      if (inv) begin
        chk({tag, "_inv"},
            32'(quotient) * 32'(e.dv) + 32'(remainder),
            32'(e.dd));
        chk({tag, "_rltd"}, remainder < e.dv, 1'b1);
      end
    end
    q_hold = quotient;
    if (inj_done) begin
      start    = 1'b1;
      dividend = 8'd77;
      divisor  = 8'd4;
    end
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_ready_after"}, ready, 1'b1);
    chk({tag, "_done_pulse"}, done, 1'b0);
    if (inj_done) begin
      @(negedge clk);
      chk({tag, "_done_start_ign"}, ready, 1'b1);
      chk({tag, "_q_hold"}, quotient, q_hold);
    end
  endtask

  initial begin
    int   lat;
    exp_t e;
    logic [7:0] ra;
    logic [7:0] rb;

    rst_b = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    chk("rst_ready", ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_q", quotient, 8'd0);
    chk("rst_r", remainder, 8'd0);
    chk("rst_dbz", div_by_zero, 1'b0);

    start_op(8'd100, 8'd7);
    wait_done(10, "d100_7", 0, 1'b0, 1'b1);

    start_op(8'd255, 8'd1);
    wait_done(10, "d255_1", 0, 1'b0, 1'b1);

    start_op(8'd5, 8'd9);
    wait_done(10, "d5_9", 0, 1'b0, 1'b1);

    start_op(8'd42, 8'd0);
    wait_done(1, "d42_0", 0, 1'b0, 1'b0);

    start_op(8'd9, 8'd3);
    wait_done(10, "d9_3", 0, 1'b0, 1'b1);

    start_op(8'd123, 8'd10);
    wait_done(10, "busy", 4, 1'b0, 1'b1);

    start_op(8'd77, 8'd5);
    wait_done(10, "donecyc", 0, 1'b1, 1'b1);

    // Reset while iterating; the pending entry is dropped.
    start_op(8'd250, 8'd3);
    lat = 0;
    while (lat < 5) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      start = 1'b0;
    end
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    e = sbq.pop_front();
    chk("mrst_ready", ready, 1'b1);
    chk("mrst_done", done, 1'b0);
    chk("mrst_q", quotient, 8'd0);
    chk("mrst_r", remainder, 8'd0);
    chk("mrst_dbz", div_by_zero, 1'b0);

    start_op(8'd200, 8'd13);
    wait_done(10, "d200_13", 0, 1'b0, 1'b1);

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(1, 255));
      start_op(ra, rb);
      wait_done(10, "rand", 0, 1'b0, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
